acc_collector: RTL and testbench
================================

# acc_collector

Result-side counterpart of the complex multiply-accumulate datapath. It watches the accumulator output and its completion flag, and captures one signed fixed-point accumulator word per rising edge of the flag into an on-chip result buffer. It signals when a programmed frame of results is complete and exposes a registered random-access read port, so results can be drained without a simulation file dump.

## Interface
- NBIT, 32, accumulator word width (Q11.21, bits [10:-21])
- NDIR, 4, buffer address width; depth = 2^NDIR words

- clk  in  1  system clock (fast clock, not the slow datapath clock)
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: load frame_len, clear pointers/flags, enter COLLECT
- clr  in  1  one-cycle pulse: abort, return to IDLE (buffer contents kept)
- frame_len  in  NDIR+1  results per frame; 0 means 2^NDIR; values above 2^NDIR clamp to 2^NDIR
- flag_in  in  1  accumulator-valid level from datapath (may stay high many clk cycles)
- acc_in  in  NBIT signed  accumulator value, stable while flag_in high
- rd_en  in  1  read request
- rd_addr  in  NDIR  read address
- rd_data  out  NBIT signed  read data
- rd_valid  out  1  rd_data valid
- count  out  NDIR+1  words captured in current frame
- busy  out  1  state == COLLECT
- done  out  1  frame complete (level)
- ovf  out  1  sticky: flag edge arrived while done

## Operation
- States: IDLE, COLLECT, DONE. Reset -> IDLE.
- IDLE: start -> COLLECT. Flag edges ignored, no ovf.
- COLLECT: rising flag edge (flag_in=1, flag_q=0) writes acc_in to mem[wr_ptr], wr_ptr+1, count+1. When post-increment count == frame_len -> DONE.
- DONE: start -> COLLECT (count, wr_ptr, done, ovf cleared). Flag edge -> ovf=1, write behaviour per Configuration.
- clr from any state -> IDLE, clears count, wr_ptr, done, ovf; takes priority over start and over a same-cycle flag edge.
- start in COLLECT restarts the frame; a same-cycle flag edge is dropped.
- flag_q resets to 1: a flag already high when reset releases produces no capture.
- Values stored unmodified, no rounding or saturation.
- Read port is independent of the FSM and works in every state. A same-cycle read and write to the same address returns the old word (read-before-write).

## Timing
- Reset values: rd_data=0, rd_valid=0, count=0, busy=0, done=0, ovf=0; wr_ptr=0, flag_q=1.
- Capture: acc_in is sampled on the same clk edge that sees flag_in=1 and flag_q=0. count updates on that edge, so it is visible one cycle after the rising edge of flag_in.
- done rises on the edge that captures the last word, together with the count update.
- Read latency: 1 cycle. rd_valid is rd_en delayed by one cycle; rd_data is held when rd_en=0.
- Minimum flag low time between captures: 1 clk cycle.
- Reset mid-frame: everything returns to reset values immediately. Buffer contents are undefined after reset.

## Configuration
- COLLECT_WRAP_EN defined:
  - in DONE, flag edges keep writing;
  - wr_ptr wraps modulo frame_len, overwriting the oldest word;
  - count holds at frame_len;
  - ovf sets on the first such write.
- COLLECT_WRAP_EN undefined: flag edges in DONE are dropped (no write) and set ovf.

## Structure
- Package col_pkg holds:
  - state enum (IDLE, COLLECT, DONE);
  - default NBIT/NDIR;
  - fixed-point constants ACC_INT=11, ACC_FRAC=21.
- Sub-module col_ram: simple dual-port RAM, 2^NDIR x NBIT, one write port and one registered read port, read-before-write.
- acc_collector holds the FSM, edge detector, pointers and status flags.

## Test plan
- Reset with flag_in held high, release, start with frame_len=4: no capture until flag drops and rises again; count=0 until then.
- frame_len=4, four flag pulses with acc_in=0x00200000 (1.0), 0xFFE00000 (-1.0), 0x7FFFFFFF, 0x80000000: count steps 1..4, done rises with the 4th capture, and reads of addresses 0..3 return the same four values with rd_valid one cycle after rd_en.
- Flag held high for 10 clk cycles: exactly one capture.
- After done, a fifth pulse with acc_in=0x12345678: ovf=1. Without COLLECT_WRAP_EN, mem[0] stays 0x00200000. With COLLECT_WRAP_EN, mem[0]=0x12345678 and count stays 4.
- frame_len=0: done only after 16 captures; clr at count=7 -> IDLE, count=0, done=0, and earlier contents still readable.
- Read addr 2 on the same cycle as the capture writing addr 2 (frame_len=8): rd_data returns the previous content of addr 2; the next read returns the new word.

Source files
------------

// File: rtl/col_pkg.sv
// Shared types and constants for the accumulator result collector.
// Q11.21 accumulator format: ACC_INT integer bits, ACC_FRAC fraction bits.
package col_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } col_state_e;

    localparam int ACC_INT  = 11;
    localparam int ACC_FRAC = 21;
    localparam int NBIT_DEF = ACC_INT + ACC_FRAC;
    localparam int NDIR_DEF = 4;

endpackage

// File: rtl/col_ram.sv
// Simple dual-port result buffer: one write port, one registered read port.
// A same-cycle read and write of one address returns the old word.
module col_ram #(
    parameter int NBIT = 32,
    parameter int NDIR = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [NDIR-1:0] wr_addr,
    input  logic [NBIT-1:0] wr_data,
    input  logic            rd_en,
    input  logic [NDIR-1:0] rd_addr,
    output logic [NBIT-1:0] rd_data,
    output logic            rd_valid
);

    logic [NBIT-1:0] mem [2**NDIR];

    // Storage is not reset; contents are undefined after reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/acc_collector.sv
// Captures one accumulator word per rising edge of flag_in into a result buffer.
// Define COLLECT_WRAP_EN to keep writing (circularly) after the frame completes.
//
// state   | meaning
// IDLE    | waiting for start, flag edges ignored
// COLLECT | capturing words until count reaches the frame length
// DONE    | frame complete, further flag edges raise ovf
module acc_collector
    import col_pkg::*;
#(
    parameter int NBIT = NBIT_DEF,
    parameter int NDIR = NDIR_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   clr,
    input  logic [NDIR:0]          frame_len,
    input  logic                   flag_in,
    input  logic signed [NBIT-1:0] acc_in,
    input  logic                   rd_en,
    input  logic [NDIR-1:0]        rd_addr,
    output logic signed [NBIT-1:0] rd_data,
    output logic                   rd_valid,
    output logic [NDIR:0]          count,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf
);

    localparam logic [NDIR:0]   DEPTH = {1'b1, {NDIR{1'b0}}};
    localparam logic [NDIR:0]   ONE   = {{NDIR{1'b0}}, 1'b1};
    localparam logic [NDIR-1:0] P_ONE = {{(NDIR-1){1'b0}}, 1'b1};

    col_state_e      state_q, state_d;
    logic [NDIR:0]   count_d, len_q, len_d, len_eff, count_inc;
    logic [NDIR-1:0] ptr_q, ptr_d, ptr_inc;
    logic            ovf_d, flag_q, flag_rise, we;

    assign flag_rise = flag_in & ~flag_q;
    assign len_eff   = (frame_len == '0 || frame_len > DEPTH) ? DEPTH : frame_len;
    assign count_inc = count + ONE;
    // Pointer wraps at the frame length so wrap mode overwrites the oldest word.
    assign ptr_inc   = ({1'b0, ptr_q} + ONE == len_q) ? '0 : ptr_q + P_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count   <= '0;
            ptr_q   <= '0;
            len_q   <= DEPTH;
            ovf     <= 1'b0;
            flag_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            count   <= count_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            ovf     <= ovf_d;
            flag_q  <= flag_in;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count;
        ptr_d   = ptr_q;
        len_d   = len_q;
        ovf_d   = ovf;
        we      = 1'b0;
        if (clr) begin
            state_d = IDLE;
            count_d = '0;
            ptr_d   = '0;
            ovf_d   = 1'b0;
        end else if (start) begin
            state_d = COLLECT;
            count_d = '0;
            ptr_d   = '0;
            ovf_d   = 1'b0;
            len_d   = len_eff;
        end else if (flag_rise) begin
            case (state_q)
                COLLECT: begin
                    we      = 1'b1;
                    count_d = count_inc;
                    ptr_d   = ptr_inc;
                    if (count_inc == len_q) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    ovf_d = 1'b1;
`ifdef COLLECT_WRAP_EN
                    we    = 1'b1;
                    ptr_d = ptr_inc;
`endif
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q == COLLECT);
    assign done = (state_q == DONE);

    col_ram #(.NBIT(NBIT), .NDIR(NDIR)) u_ram (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .wr_addr  (ptr_q),
        .wr_data  (acc_in),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

endmodule

// File: tb/tb_acc_collector.sv
// Self-checking bench for acc_collector: directed scenarios plus random traffic
// against a frame-level reference model of the collector.
module tb_acc_collector;

    localparam int NB    = 32;
    localparam int ND    = 4;
    localparam int DEPTH = 16;

    logic                 clk = 1'b0;
    logic                 rst, start, clr, flag_in, rd_en;
    logic [ND:0]          frame_len;
    logic signed [NB-1:0] acc_in;
    logic [ND-1:0]        rd_addr;
    logic signed [NB-1:0] rd_data;
    logic                 rd_valid, busy, done, ovf;
    logic [ND:0]          count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    acc_collector #(.NBIT(NB), .NDIR(ND)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clr       (clr),
        .frame_len (frame_len),
        .flag_in   (flag_in),
        .acc_in    (acc_in),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    // Reference model: phase 0 idle, 1 collecting, 2 frame full.
    logic [NB-1:0] mem_m [DEPTH];
    bit            known_m [DEPTH];
    int            phase_m, cnt_m, wp_m, len_m;
    bit            ovf_m, flag_prev_m, rdv_m, rdk_m;
    logic [NB-1:0] rd_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        phase_m = 0; cnt_m = 0; wp_m = 0; len_m = DEPTH; ovf_m = 0;
        flag_prev_m = 1; rdv_m = 0; rdk_m = 1; rd_m = '0;
        for (int i = 0; i < DEPTH; i++) known_m[i] = 0;
    endtask

    task automatic cyc(input bit st, input bit cl, input logic [ND:0] fl, input bit fg,
                       input logic [NB-1:0] acc, input bit re, input logic [ND-1:0] ra);
        bit rise;
        start = st; clr = cl; frame_len = fl; flag_in = fg;
        acc_in = acc; rd_en = re; rd_addr = ra;
        rise = fg && !flag_prev_m;
        flag_prev_m = fg;
        if (re) begin
            rd_m  = mem_m[ra];
            rdk_m = known_m[ra];
        end
        rdv_m = re;
        if (cl) begin
            phase_m = 0; cnt_m = 0; wp_m = 0; ovf_m = 0;
        end else if (st) begin
            phase_m = 1; cnt_m = 0; wp_m = 0; ovf_m = 0;
            len_m = (fl == 0 || int'(fl) > DEPTH) ? DEPTH : int'(fl);
        end else if (rise && phase_m == 1) begin
            mem_m[wp_m] = acc; known_m[wp_m] = 1;
            cnt_m++;
            wp_m = (wp_m + 1) % len_m;
            if (cnt_m == len_m) phase_m = 2;
        end else if (rise && phase_m == 2) begin
            ovf_m = 1;
`ifdef COLLECT_WRAP_EN
            mem_m[wp_m] = acc; known_m[wp_m] = 1;
            wp_m = (wp_m + 1) % len_m;
`endif
        end
        @(posedge clk);
        #1;
        check("count", 32'(count), 32'(cnt_m));
        check("busy", 32'(busy), 32'(phase_m == 1));
        check("done", 32'(done), 32'(phase_m == 2));
        check("ovf", 32'(ovf), 32'(ovf_m));
        check("rd_valid", 32'(rd_valid), 32'(rdv_m));
        if (rdk_m) check("rd_data", rd_data, rd_m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, '0, 0, '0);
    endtask

    task automatic pulse(input logic [NB-1:0] acc, input int hi);
        for (int i = 0; i < hi; i++) cyc(0, 0, '0, 1, acc, 0, '0);
        cyc(0, 0, '0, 0, acc, 0, '0);
    endtask

    logic [NB-1:0] vals [4];
    logic [NB-1:0] old2, new2;

    initial begin
        vals[0] = 32'h0020_0000; vals[1] = 32'hFFE0_0000;
        vals[2] = 32'h7FFF_FFFF; vals[3] = 32'h8000_0000;
        rst = 1; start = 0; clr = 0; frame_len = '0; flag_in = 1;
        acc_in = '0; rd_en = 0; rd_addr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", rd_data, 0);
        rst = 0;

        // Flag already high at reset release must not capture.
        cyc(1, 0, 5'd4, 1, 32'hDEAD_BEEF, 0, '0);
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1, 32'hDEAD_BEEF, 0, '0);
        check("no_capture_high_flag", 32'(count), 0);
        cyc(0, 0, '0, 0, '0, 0, '0);

        pulse(vals[0], 10);
        check("one_capture_long_flag", 32'(count), 1);
        for (int i = 1; i < 4; i++) begin
            pulse(vals[i], 1);
            check("count_step", 32'(count), 32'(i + 1));
        end
        check("done_after_4", 32'(done), 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, '0, 0, '0, 1, ND'(i));
            check("rd_frame4", rd_data, vals[i]);
            check("rd_valid_lat", 32'(rd_valid), 1);
        end
        idle(1);
        check("rd_valid_drop", 32'(rd_valid), 0);

        pulse(32'h1234_5678, 1);
        check("ovf_after_done", 32'(ovf), 1);
        check("count_hold_ovf", 32'(count), 4);
        cyc(0, 0, '0, 0, '0, 1, '0);
`ifdef COLLECT_WRAP_EN
        check("mem0_after_ovf", rd_data, 32'h1234_5678);
`else
        check("mem0_after_ovf", rd_data, 32'h0020_0000);
`endif

        // frame_len 0 means full depth; clr mid-frame keeps contents.
        cyc(1, 0, 5'd0, 0, '0, 0, '0);
        for (int i = 0; i < 7; i++) pulse($urandom, 1);
        check("count7", 32'(count), 7);
        cyc(0, 1, '0, 0, '0, 0, '0);
        check("clr_count", 32'(count), 0);
        check("clr_done", 32'(done), 0);
        check("clr_busy", 32'(busy), 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, '0, 0, '0, 1, ND'(i));
        cyc(1, 0, 5'd0, 0, '0, 0, '0);
        for (int i = 0; i < 15; i++) pulse($urandom, 1);
        check("not_done_15", 32'(done), 0);
        pulse($urandom, 1);
        check("done_16", 32'(done), 1);
        check("count_16", 32'(count), 16);

        // Read-before-write on address 2.
        cyc(1, 0, 5'd8, 0, '0, 0, '0);
        pulse($urandom, 1);
        pulse($urandom, 1);
        old2 = mem_m[2];
        new2 = $urandom;
        cyc(0, 0, '0, 1, new2, 1, 5'd2);
        check("rbw_old", rd_data, old2);
        cyc(0, 0, '0, 0, '0, 1, 5'd2);
        check("rbw_new", rd_data, new2);

        // Clamped frame length.
        cyc(1, 0, 5'd20, 0, '0, 0, '0);
        for (int i = 0; i < 16; i++) pulse($urandom, 1);
        check("clamp_done", 32'(done), 1);

        // Reset mid-frame.
        cyc(1, 0, 5'd6, 0, '0, 0, '0);
        pulse($urandom, 1);
        flag_in = 1;
        #2 rst = 1;
        #1;
        check("midrst_count", 32'(count), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_rd_valid", 32'(rd_valid), 0);
        model_reset();
        @(posedge clk);
        #1 rst = 0;
        cyc(1, 0, 5'd3, 1, '0, 0, '0);
        check("midrst_nocap", 32'(count), 0);

        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 40) == 0, $urandom_range(0, 70) == 0,
                5'($urandom_range(0, 31)), $urandom_range(0, 2) != 0, $urandom,
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
